pid_pwm_controller: RTL and testbench

Parametrised single-clock PID focus loop with integrated PWM output, the successor to the dual-clock focus controller. Replaces the separate slow clock with an internal sample-rate divider and uses one shared multiplier stepped by an FSM. Adds a deadband, saturating arithmetic, glitch-free PWM duty updates and an integrator clear. Sits between the focus-error front end and the focus actuator driver.

---
 rtl/pid_pwm_controller_if.sv | 32 +++
 rtl/pid_pwm_controller.sv | 258 +++++++++++++++++++++++++
 tb/tb_pid_pwm_controller.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_pwm_controller_if.sv
// Port bundle for pid_pwm_controller: loop controls, measured/target values,
// gains, and the duty/PWM outputs. The slave modport is the controller side.
interface pid_pwm_controller_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned PWM_W = 8
);

  logic                 enable;
  logic                 clear_int;
  logic signed [DW-1:0] focus_signal;
  logic signed [DW-1:0] setpoint;
  logic signed [DW-1:0] threshold;
  logic signed [DW-1:0] kp;
  logic signed [DW-1:0] ki;
  logic signed [DW-1:0] kd;
  logic [PWM_W-1:0]     duty;
  logic                 update_valid;
  logic                 sat_hi;
  logic                 sat_lo;
  logic                 pwm_out;

  modport master (
    output enable, clear_int, focus_signal, setpoint, threshold, kp, ki, kd,
    input  duty, update_valid, sat_hi, sat_lo, pwm_out
  );

  modport slave (
    input  enable, clear_int, focus_signal, setpoint, threshold, kp, ki, kd,
    output duty, update_valid, sat_hi, sat_lo, pwm_out
  );

endinterface

// File: rtl/pid_pwm_controller.sv
// Single-clock PID focus loop with integrated PWM output. A sample divider
// starts one pass of a small FSM that steps one shared multiplier through the
// P, I and D products, sums with saturation and loads a new duty value.
// Optional build macro: PID_ANTIWINDUP_EN clamps the integrator to +/-INT_LIMIT.
module pid_pwm_controller #(
  parameter int unsigned DW         = 16,
  parameter int unsigned FRAC       = 8,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned SAMPLE_DIV = 20,
  parameter int unsigned INT_LIMIT  = 32768
) (
  input logic                 clk,
  input logic                 reset,
  pid_pwm_controller_if.slave bus
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned EW   = DW + 1;      // error width
  localparam int unsigned MW   = 2 * DW + 2;  // full product width

  localparam logic [DivW-1:0]         DivLast = DivW'(SAMPLE_DIV - 1);
  localparam logic signed [ACC_W-1:0] AccMax  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W+1:0] SumMax  = {2'b00, AccMax};
  localparam logic signed [ACC_W+1:0] SumMin  = {2'b11, AccMin};
  localparam logic [PWM_W-1:0]        DutyMid = {1'b1, {(PWM_W-1){1'b0}}};
  localparam logic [PWM_W-1:0]        DutyMax = {PWM_W{1'b1}};
  localparam logic signed [ACC_W:0]   VMax    = {{(ACC_W+1-PWM_W){1'b0}}, DutyMax};

  if (SAMPLE_DIV < 8 || ACC_W < 2 * DW + 3 || INT_LIMIT == 0) begin : g_param_check
    $error("pid_pwm_controller: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    StIdle, StErr, StMulP, StMulI, StMulD, StSum, StOut
  } state_e;

  state_e state_q, state_d;

  logic [DivW-1:0] div_q;
  logic            tick;

  logic signed [DW-1:0]    focus_q, setpoint_q, threshold_q, kp_q, ki_q, kd_q;
  logic signed [EW-1:0]    e_q, e_prev_q, e_d, diff;
  logic signed [EW:0]      diff_ext, diff_abs, th_eff;
  logic signed [ACC_W-1:0] p_q, d_q, integ_q;

  logic signed [DW-1:0]    mul_a;
  logic signed [EW:0]      mul_b;
  logic signed [MW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;

  logic signed [ACC_W:0]   integ_sum;
  logic signed [ACC_W-1:0] integ_sat, integ_new;

  logic signed [ACC_W+1:0] sum_w;
  logic signed [ACC_W-1:0] sum_sat, u;
  logic signed [ACC_W:0]   v;
  logic [PWM_W-1:0]        duty_d, duty_q;
  logic                    hi_d, lo_d, sat_hi_q, sat_lo_q;

  logic [PWM_W-1:0]        cnt_q, active_q;
  logic                    pwm_q;

  assign tick = bus.enable && (div_q == DivLast);

  // Sample-rate divider; frozen while enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (bus.enable) begin
      div_q <= tick ? '0 : div_q + DivW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // One pass per tick; a started pass always runs to StOut.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (tick) state_d = StErr;
      StErr:   state_d = StMulP;
      StMulP:  state_d = StMulI;
      StMulI:  state_d = StMulD;
      StMulD:  state_d = StSum;
      StSum:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Error with deadband; a negative threshold acts as zero.
  always_comb begin
    diff     = {focus_q[DW-1], focus_q} - {setpoint_q[DW-1], setpoint_q};
    diff_ext = {diff[EW-1], diff};
    diff_abs = diff[EW-1] ? -diff_ext : diff_ext;
    th_eff   = threshold_q[DW-1] ? '0 : {2'b00, threshold_q};
    e_d      = (diff_abs <= th_eff) ? '0 : diff;
  end

  // Operand select for the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      StMulP: begin
        mul_a = kp_q;
        mul_b = {e_q[EW-1], e_q};
      end
      StMulI: begin
        mul_a = ki_q;
        mul_b = {e_q[EW-1], e_q};
      end
      StMulD: begin
        mul_a = kd_q;
        mul_b = {e_q[EW-1], e_q} - {e_prev_q[EW-1], e_prev_q};
      end
      default: ;
    endcase
  end

  assign prod     = $signed({{(MW-DW){mul_a[DW-1]}}, mul_a}) *
                    $signed({{(MW-EW-1){mul_b[EW]}}, mul_b});
  assign prod_ext = {{(ACC_W-MW){prod[MW-1]}}, prod};

  // Integrator update saturated to the accumulator range.
  always_comb begin
    integ_sum = {integ_q[ACC_W-1], integ_q} + {prod_ext[ACC_W-1], prod_ext};
    if (integ_sum[ACC_W] != integ_sum[ACC_W-1]) begin
      integ_sat = integ_sum[ACC_W] ? AccMin : AccMax;
    end else begin
      integ_sat = integ_sum[ACC_W-1:0];
    end
  end

`ifdef PID_ANTIWINDUP_EN
  localparam logic signed [ACC_W-1:0] IntHi = ACC_W'(INT_LIMIT);
  localparam logic signed [ACC_W-1:0] IntLo = -IntHi;

  // Anti-windup clamp on the integrator.
  always_comb begin
    integ_new = integ_sat;
    if (integ_sat > IntHi) begin
      integ_new = IntHi;
    end else if (integ_sat < IntLo) begin
      integ_new = IntLo;
    end
  end
`else
  assign integ_new = integ_sat;
`endif

  // Sum, scale back to integer, centre on mid-scale and clip into duty range.
  always_comb begin
    sum_w = {{2{p_q[ACC_W-1]}}, p_q} + {{2{integ_q[ACC_W-1]}}, integ_q}
          + {{2{d_q[ACC_W-1]}}, d_q};
    if (sum_w > SumMax) begin
      sum_sat = AccMax;
    end else if (sum_w < SumMin) begin
      sum_sat = AccMin;
    end else begin
      sum_sat = sum_w[ACC_W-1:0];
    end
    u      = sum_sat >>> FRAC;
    v      = {u[ACC_W-1], u} + {{(ACC_W+1-PWM_W){1'b0}}, DutyMid};
    hi_d   = v > VMax;
    lo_d   = v[ACC_W];
    duty_d = hi_d ? DutyMax : (lo_d ? '0 : v[PWM_W-1:0]);
  end

  // Input snapshot and per-pass products, stepped by the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      focus_q     <= '0;
      setpoint_q  <= '0;
      threshold_q <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      e_q         <= '0;
      p_q         <= '0;
      d_q         <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tick) begin
            focus_q     <= bus.focus_signal;
            setpoint_q  <= bus.setpoint;
            threshold_q <= bus.threshold;
            kp_q        <= bus.kp;
            ki_q        <= bus.ki;
            kd_q        <= bus.kd;
          end
        end
        StErr:   e_q <= e_d;
        StMulP:  p_q <= prod_ext;
        StMulD:  d_q <= prod_ext;
        default: ;
      endcase
    end
  end

  // Loop memory; clear_int overrides any same-cycle update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      integ_q  <= '0;
      e_prev_q <= '0;
    end else if (bus.clear_int) begin
      integ_q  <= '0;
      e_prev_q <= '0;
    end else begin
      if (state_q == StMulI) integ_q <= integ_new;
      if (state_q == StMulD) e_prev_q <= e_q;
    end
  end

  // Duty and saturation flags load at the end of StSum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q   <= DutyMid;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else if (state_q == StSum) begin
      duty_q   <= duty_d;
      sat_hi_q <= hi_d;
      sat_lo_q <= lo_d;
    end
  end

  // Free-running PWM; duty only reloads at period end so edges never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= DutyMid;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_W'(1);
      if (cnt_q == DutyMax) active_q <= duty_q;
      pwm_q <= cnt_q < active_q;
    end
  end

  assign bus.duty         = duty_q;
  assign bus.update_valid = (state_q == StOut);
  assign bus.sat_hi       = sat_hi_q;
  assign bus.sat_lo       = sat_lo_q;
  assign bus.pwm_out      = pwm_q;

endmodule

// File: tb/tb_pid_pwm_controller.sv
// Bench for pid_pwm_controller: a table of single-sample vectors with
// hand-computed duties, then directed sequences for integrator, clear_int,
// enable drop and reset during a pass.
module tb_pid_pwm_controller;

  localparam int unsigned DW         = 16;
  localparam int unsigned FRAC       = 8;
  localparam int unsigned ACC_W      = 40;
  localparam int unsigned PWM_W      = 8;
  localparam int unsigned SAMPLE_DIV = 20;
  localparam int unsigned INT_LIMIT  = 32768;
  localparam int          Period     = 1 << PWM_W;
  localparam int          DutyMid    = 1 << (PWM_W - 1);
  localparam int          UpdTimeout = 2 * SAMPLE_DIV + 10;
  localparam int          NumVecs    = 22;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pid_pwm_controller_if #(.DW(DW), .PWM_W(PWM_W)) bus ();

  pid_pwm_controller #(
    .DW        (DW),
    .FRAC      (FRAC),
    .ACC_W     (ACC_W),
    .PWM_W     (PWM_W),
    .SAMPLE_DIV(SAMPLE_DIV),
    .INT_LIMIT (INT_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int focus;
    int setpoint;
    int threshold;
    int kp;
    int kd;
    int exp_duty;
    int exp_hi;
    int exp_lo;
    int exp_pwm;  // -1: no PWM window count
  } vec_t;

  vec_t vecs [NumVecs];
  int   integ_focus [5];
  int   integ_exp [5];
  int   checks;
  int   errors;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_inputs(input int f, input int sp, input int th,
                            input int p, input int i, input int d);
    bus.focus_signal = DW'(f);
    bus.setpoint     = DW'(sp);
    bus.threshold    = DW'(th);
    bus.kp           = DW'(p);
    bus.ki           = DW'(i);
    bus.kd           = DW'(d);
  endtask

  // Returns at the negedge where update_valid is seen; cyc counts negedges.
  task automatic wait_update(input string name, output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    while (cyc < UpdTimeout) begin
      @(negedge clk);
      cyc++;
      if (bus.update_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no update_valid within %0d cycles", name, UpdTimeout);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " duty"}, bus.duty, DutyMid);
    check({tag, " update_valid"}, bus.update_valid, 0);
    check({tag, " sat_hi"}, bus.sat_hi, 0);
    check({tag, " sat_lo"}, bus.sat_lo, 0);
    check({tag, " pwm_out"}, bus.pwm_out, 0);
  endtask

  task automatic count_pwm(output int highs);
    highs = 0;
    for (int k = 0; k < Period; k++) begin
      @(negedge clk);
      if (bus.pwm_out) highs++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int highs;
    int n_upd;

    checks = 0;
    errors = 0;

    //             focus   sp      th     kp    kd   duty hi lo pwm
    vecs[0]  = '{    10,      0,     0,  256,   0, 138, 0, 0, 138};
    vecs[1]  = '{  -200,      0,     0,  256,   0,   0, 0, 1,   0};
    vecs[2]  = '{   200,      0,     0,  256,   0, 255, 1, 0, 255};
    vecs[3]  = '{     4,      0,     5,  256,   0, 128, 0, 0,  -1};
    vecs[4]  = '{     6,      0,     5,  256,   0, 134, 0, 0,  -1};
    vecs[5]  = '{     5,      0,     5,  256,   0, 128, 0, 0,  -1};
    vecs[6]  = '{    -5,      0,     5,  256,   0, 128, 0, 0,  -1};
    vecs[7]  = '{    -6,      0,     5,  256,   0, 122, 0, 0,  -1};
    vecs[8]  = '{     1,      0,    -3,  256,   0, 129, 0, 0,  -1};
    vecs[9]  = '{    30,     20,     0,  512,   0, 148, 0, 0,  -1};
    vecs[10] = '{    10,      0,     0, -256,   0, 118, 0, 0,  -1};
    vecs[11] = '{    11,      0,     0,  128,   0, 133, 0, 0,  -1};
    vecs[12] = '{   -11,      0,     0,  128,   0, 122, 0, 0,  -1};
    // derivative: e_prev is -11 from the vector above
    vecs[13] = '{     0,      0,     0,    0, 256, 139, 0, 0,  -1};
    vecs[14] = '{     0,      0,     0,    0, 256, 128, 0, 0,  -1};
    vecs[15] = '{    50,      0,     0,    0, 256, 178, 0, 0,  -1};
    vecs[16] = '{    50,      0,     0,    0, 256, 128, 0, 0,  -1};
    vecs[17] = '{   -20,      0,     0,  256, 256,  38, 0, 0,  -1};
    // error needs DW+1 bits at the extremes
    vecs[18] = '{ 32767, -32768,     0,  256,   0, 255, 1, 0,  -1};
    vecs[19] = '{-32768,  32767,     0,    1,   0,   0, 0, 1,  -1};
    vecs[20] = '{ 32767,      0, 32767,  256,   0, 128, 0, 0,  -1};
    vecs[21] = '{-32768,      0, 32767,  256,   0,   0, 0, 1,  -1};

    integ_focus = '{100, 100, 100, -100, -100};
`ifdef PID_ANTIWINDUP_EN
    integ_exp = '{228, 255, 255, 156, 56};
`else
    integ_exp = '{228, 255, 255, 255, 228};
`endif

    // Reset state and first-sample latency
    bus.enable    = 1'b1;
    bus.clear_int = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    set_inputs(10, 0, 0, 256, 0, 0);
    reset = 1'b0;
    wait_update("first update", cyc);
    check("first update latency", cyc, SAMPLE_DIV + 5);
    check("first update duty", bus.duty, 138);
    @(negedge clk);
    check("update_valid width", bus.update_valid, 0);
    wait_update("second update", cyc);
    check("sample spacing", cyc, SAMPLE_DIV - 1);

    // Table of single-sample vectors
    for (int i = 0; i < NumVecs; i++) begin
      set_inputs(vecs[i].focus, vecs[i].setpoint, vecs[i].threshold,
                 vecs[i].kp, 0, vecs[i].kd);
      wait_update($sformatf("vec%0d update", i), cyc);
      check($sformatf("vec%0d duty", i), bus.duty, vecs[i].exp_duty);
      check($sformatf("vec%0d sat_hi", i), bus.sat_hi, vecs[i].exp_hi);
      check($sformatf("vec%0d sat_lo", i), bus.sat_lo, vecs[i].exp_lo);
      if (vecs[i].exp_pwm >= 0) begin
        repeat (Period + 2) @(negedge clk);
        count_pwm(highs);
        check($sformatf("vec%0d pwm high count", i), highs, vecs[i].exp_pwm);
        wait_update($sformatf("vec%0d resync", i), cyc);
      end
    end

    // Integrator run-up and unwind
    set_inputs(100, 0, 0, 0, 256, 0);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_inputs(integ_focus[i], 0, 0, 0, 256, 0);
      wait_update($sformatf("integ%0d update", i), cyc);
      check($sformatf("integ%0d duty", i), bus.duty, integ_exp[i]);
    end

    // clear_int during MUL_I of the second sample
    set_inputs(100, 0, 0, 0, 256, 0);
    apply_reset();
    wait_update("clear first", cyc);
    check("clear first duty", bus.duty, 228);
    repeat (17) @(negedge clk);
    bus.clear_int = 1'b1;
    @(negedge clk);
    bus.clear_int = 1'b0;
    check("clear keeps duty", bus.duty, 228);
    wait_update("clear pass", cyc);
    check("clear pass latency", cyc, 2);
    check("clear wins over integ update", bus.duty, 128);
    wait_update("after clear", cyc);
    check("integ restarts from zero", bus.duty, 228);

    // enable dropped mid-pass
    set_inputs(10, 0, 0, 256, 0, 0);
    apply_reset();
    wait_update("enable first", cyc);
    repeat (17) @(negedge clk);
    bus.enable = 1'b0;
    wait_update("enable pass completes", cyc);
    check("enable pass latency", cyc, 3);
    check("enable pass duty", bus.duty, 138);
    n_upd = 0;
    repeat (3 * SAMPLE_DIV) begin
      @(negedge clk);
      if (bus.update_valid) n_upd++;
    end
    check("no updates while disabled", n_upd, 0);
    bus.enable = 1'b1;
    wait_update("re-enable", cyc);
    check("divider resumes from held count", cyc, SAMPLE_DIV + 3);

    // Reset asserted during MUL_D
    set_inputs(200, 0, 0, 256, 0, 0);
    wait_update("pre-reset", cyc);
    check("pre-reset duty", bus.duty, 255);
    check("pre-reset sat_hi", bus.sat_hi, 1);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    n_upd = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.update_valid) n_upd++;
    end
    check("no update_valid in reset", n_upd, 0);
    check_reset_values("mid-pass reset");
    reset = 1'b0;
    wait_update("post-reset", cyc);
    check("post-reset latency", cyc, SAMPLE_DIV + 5);
    check("post-reset duty", bus.duty, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
